// File: rtl/traffic_pkg.sv
// Encodings shared between the traffic light controller and the pedestrian
// signal controller.
package traffic_pkg;

    localparam int unsigned LIGHT_W = 3;
    localparam int unsigned PED_W   = 2;
    localparam int unsigned CNT_W   = 6;

    localparam logic [LIGHT_W-1:0] LIGHT_OFF    = 3'b000;
    localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b001;
    localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
    localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b100;

    localparam logic [PED_W-1:0] PED_DARK  = 2'd0;
    localparam logic [PED_W-1:0] PED_IDLE  = 2'd1;
    localparam logic [PED_W-1:0] PED_WALK  = 2'd2;
    localparam logic [PED_W-1:0] PED_CLEAR = 2'd3;

    // Only the three one-hot lamp codes count as a live light; anything else is OFF.
    function automatic logic light_active(input logic [LIGHT_W-1:0] light);
        return (light == LIGHT_RED) || (light == LIGHT_YELLOW) || (light == LIGHT_GREEN);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ped_btn_debounce.sv
// Push-button synchronizer and debouncer; emits one registered press pulse
// per qualified hold.
module ped_btn_debounce #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_btn,
    output logic press
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= ped_btn;
            sync2 <= sync1;
            // Pulse only on the step into DEBOUNCE; saturation blocks repeats.
            press <= sync2 && (db_cnt == DB_W'(DEBOUNCE - 1));
            if (!sync2) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_W'(DEBOUNCE)) begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: serves latched requests at the start of RED
// and drives WALK / DON'T WALK lamps plus the clearance countdown.
module ped_signal_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned WALK_TIME  = 20,
    parameter int unsigned CLEAR_TIME = 8,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned FLASH_HALF = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LIGHT_W-1:0] light_state,
    input  logic               ped_btn,
    output logic               walk,
    output logic               dont_walk,
    output logic               ped_pending,
    output logic [CNT_W-1:0]   countdown
);

    logic               press;
    logic               red_rise;
    logic [LIGHT_W-1:0] prev_light;
    logic [PED_W-1:0]   state_q;
    logic [PED_W-1:0]   state_d;
    logic [CNT_W-1:0]   phase_q;
    logic [CNT_W-1:0]   phase_d;
    logic [CNT_W-1:0]   flash_q;
    logic [CNT_W-1:0]   flash_d;
    logic               walk_d;
    logic               dont_walk_d;
    logic               pending_d;
    logic [CNT_W-1:0]   countdown_d;

    ped_btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .ped_btn (ped_btn),
        .press   (press)
    );

    assign red_rise = (light_state == LIGHT_RED) && (prev_light != LIGHT_RED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PED_DARK;
            prev_light  <= LIGHT_OFF;
            phase_q     <= '0;
            flash_q     <= '0;
            walk        <= 1'b0;
            dont_walk   <= 1'b0;
            ped_pending <= 1'b0;
            countdown   <= '0;
        end else begin
            state_q     <= state_d;
            prev_light  <= light_state;
            phase_q     <= phase_d;
            flash_q     <= flash_d;
            walk        <= walk_d;
            dont_walk   <= dont_walk_d;
            ped_pending <= pending_d;
            countdown   <= countdown_d;
        end
    end

    // Next state plus next lamp values, so every output leaves a flop.
    always_comb begin
        state_d     = state_q;
        phase_d     = '0;
        flash_d     = '0;
        walk_d      = 1'b0;
        dont_walk_d = 1'b0;
        pending_d   = ped_pending;
        countdown_d = '0;

        if (!light_active(light_state)) begin
            state_d   = PED_DARK;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                PED_DARK: begin
                    state_d     = PED_IDLE;
                    dont_walk_d = 1'b1;
                end
                PED_IDLE: begin
                    if (red_rise && (ped_pending || press)) begin
                        state_d   = PED_WALK;
                        walk_d    = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        dont_walk_d = 1'b1;
                        if (press) begin
                            pending_d = 1'b1;
                        end
                    end
                end
                PED_WALK: begin
                    if (light_state != LIGHT_RED) begin
                        state_d     = PED_IDLE;
                        dont_walk_d = 1'b1;
                    end else if (phase_q == CNT_W'(WALK_TIME - 1)) begin
                        state_d     = PED_CLEAR;
                        dont_walk_d = 1'b1;
                        countdown_d = CNT_W'(CLEAR_TIME);
                    end else begin
                        walk_d  = 1'b1;
                        phase_d = sat_inc(phase_q);
                    end
                end
                PED_CLEAR: begin
                    if ((light_state != LIGHT_RED) || (phase_q == CNT_W'(CLEAR_TIME - 1))) begin
                        state_d     = PED_IDLE;
                        dont_walk_d = 1'b1;
                    end else begin
                        phase_d     = sat_inc(phase_q);
                        countdown_d = countdown - CNT_W'(1);
                        // Flash divider: hold the lamp FLASH_HALF cycles, then invert.
                        if (flash_q == CNT_W'(FLASH_HALF - 1)) begin
                            dont_walk_d = ~dont_walk;
                        end else begin
                            flash_d     = flash_q + CNT_W'(1);
                            dont_walk_d = dont_walk;
                        end
                    end
                end
                default: begin
                    state_d = PED_DARK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl at default parameters.
module tb_ped_signal_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] light_state;
    logic       ped_btn;
    logic       walk;
    logic       dont_walk;
    logic       ped_pending;
    logic [5:0] countdown;

    int total;
    int bad;

    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_RED = 3'b001;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b100;

    ped_signal_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .light_state (light_state),
        .ped_btn     (ped_btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .ped_pending (ped_pending),
        .countdown   (countdown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; light_state = L_GRN; ped_btn = 1'b0;
        tick(2);
        total += 4;
        if (walk !== 1'b0)        begin bad++; $display("FAIL reset_walk got=%b exp=0", walk); end
        if (dont_walk !== 1'b0)   begin bad++; $display("FAIL reset_dont_walk got=%b exp=0", dont_walk); end
        if (ped_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", ped_pending); end
        if (countdown !== 6'd0)   begin bad++; $display("FAIL reset_countdown got=%0d exp=0", countdown); end
        rst = 1'b0;
        tick();
        total += 2;
        if (dont_walk !== 1'b1) begin bad++; $display("FAIL idle_dont_walk got=%b exp=1", dont_walk); end
        if (walk !== 1'b0)      begin bad++; $display("FAIL idle_walk got=%b exp=0", walk); end
    endtask

    task automatic test_debounce;
        for (int p = 0; p < 2; p++) begin
            ped_btn = 1'b1; tick(3);
            ped_btn = 1'b0; tick(4);
            total++;
            if (ped_pending !== 1'b0) begin bad++; $display("FAIL short_pulse_%0d got=%b exp=0", p, ped_pending); end
        end
        ped_btn = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            total++;
            if (ped_pending !== (e >= 6)) begin
                bad++; $display("FAIL hold_edge_%0d pending got=%b exp=%b", e, ped_pending, (e >= 6));
            end
        end
        ped_btn = 1'b0;
        tick(3);
    endtask

    task automatic test_full_walk;
        logic [7:0] dw_pat;
        dw_pat = 8'b1100_1100;
        light_state = L_YEL; tick(3);
        light_state = L_RED;
        for (int i = 0; i < 20; i++) begin
            tick();
            total += 3;
            if (walk !== 1'b1)      begin bad++; $display("FAIL walk_cyc_%0d walk got=%b exp=1", i, walk); end
            if (dont_walk !== 1'b0) begin bad++; $display("FAIL walk_cyc_%0d dont_walk got=%b exp=0", i, dont_walk); end
            if (ped_pending !== 1'b0) begin bad++; $display("FAIL walk_cyc_%0d pending got=%b exp=0", i, ped_pending); end
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            total += 3;
            if (walk !== 1'b0) begin bad++; $display("FAIL clear_%0d walk got=%b exp=0", k, walk); end
            if (dont_walk !== dw_pat[7-k]) begin
                bad++; $display("FAIL clear_%0d dont_walk got=%b exp=%b", k, dont_walk, dw_pat[7-k]);
            end
            if (countdown !== 6'(8 - k)) begin
                bad++; $display("FAIL clear_%0d countdown got=%0d exp=%0d", k, countdown, 8 - k);
            end
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            total += 3;
            if (walk !== 1'b0)      begin bad++; $display("FAIL post_clear_%0d walk got=%b exp=0", j, walk); end
            if (dont_walk !== 1'b1) begin bad++; $display("FAIL post_clear_%0d dont_walk got=%b exp=1", j, dont_walk); end
            if (countdown !== 6'd0) begin bad++; $display("FAIL post_clear_%0d countdown got=%0d exp=0", j, countdown); end
        end
        light_state = L_GRN; tick(2);
    endtask

    task automatic test_press_mid_red;
        light_state = L_RED; tick(5);
        ped_btn = 1'b1; tick(7);
        ped_btn = 1'b0; tick(3);
        total += 2;
        if (ped_pending !== 1'b1) begin bad++; $display("FAIL mid_red_pending got=%b exp=1", ped_pending); end
        if (walk !== 1'b0)        begin bad++; $display("FAIL mid_red_walk got=%b exp=0", walk); end
        light_state = L_GRN; tick(3);
        total++;
        if (ped_pending !== 1'b1) begin bad++; $display("FAIL green_pending_held got=%b exp=1", ped_pending); end
        light_state = L_RED; tick();
        total += 2;
        if (walk !== 1'b1)        begin bad++; $display("FAIL next_red_walk got=%b exp=1", walk); end
        if (ped_pending !== 1'b0) begin bad++; $display("FAIL next_red_pending got=%b exp=0", ped_pending); end
    endtask

    task automatic test_abort;
        tick(9);
        total++;
        if (walk !== 1'b1) begin bad++; $display("FAIL pre_abort_walk got=%b exp=1", walk); end
        light_state = L_OFF; tick();
        total += 4;
        if (walk !== 1'b0)        begin bad++; $display("FAIL abort_walk got=%b exp=0", walk); end
        if (dont_walk !== 1'b0)   begin bad++; $display("FAIL abort_dont_walk got=%b exp=0", dont_walk); end
        if (ped_pending !== 1'b0) begin bad++; $display("FAIL abort_pending got=%b exp=0", ped_pending); end
        if (countdown !== 6'd0)   begin bad++; $display("FAIL abort_countdown got=%0d exp=0", countdown); end
        light_state = L_RED;
        for (int i = 0; i < 4; i++) begin
            tick();
            total += 2;
            if (walk !== 1'b0)      begin bad++; $display("FAIL red_return_%0d walk got=%b exp=0", i, walk); end
            if (dont_walk !== 1'b1) begin bad++; $display("FAIL red_return_%0d dont_walk got=%b exp=1", i, dont_walk); end
        end
    endtask

    task automatic test_invalid;
        light_state = L_GRN; tick();
        light_state = 3'b011; tick();
        total += 2;
        if (dont_walk !== 1'b0) begin bad++; $display("FAIL invalid_dont_walk got=%b exp=0", dont_walk); end
        if (walk !== 1'b0)      begin bad++; $display("FAIL invalid_walk got=%b exp=0", walk); end
        light_state = L_GRN; tick();
        total++;
        if (dont_walk !== 1'b1) begin bad++; $display("FAIL recover_dont_walk got=%b exp=1", dont_walk); end
        // Press while dark must be dropped.
        light_state = L_OFF; tick();
        ped_btn = 1'b1; tick(8);
        ped_btn = 1'b0; tick(3);
        light_state = L_GRN; tick();
        total++;
        if (ped_pending !== 1'b0) begin bad++; $display("FAIL dark_press_pending got=%b exp=0", ped_pending); end
        // Latch a request, start WALK, then press during WALK.
        ped_btn = 1'b1; tick(7);
        ped_btn = 1'b0; tick(3);
        light_state = L_RED; tick();
        total++;
        if (walk !== 1'b1) begin bad++; $display("FAIL walk_for_press got=%b exp=1", walk); end
        ped_btn = 1'b1; tick(8);
        ped_btn = 1'b0; tick(2);
        total += 2;
        if (ped_pending !== 1'b0) begin bad++; $display("FAIL walk_press_pending got=%b exp=0", ped_pending); end
        if (walk !== 1'b1)        begin bad++; $display("FAIL walk_still got=%b exp=1", walk); end
        tick(20);
        total++;
        if (ped_pending !== 1'b0) begin bad++; $display("FAIL after_walk_pending got=%b exp=0", ped_pending); end
    endtask

    task automatic test_reset_mid;
        light_state = L_GRN; ped_btn = 1'b1; tick(7);
        ped_btn = 1'b0; tick(2);
        light_state = L_RED; tick(3);
        total++;
        if (walk !== 1'b1) begin bad++; $display("FAIL mid_setup_walk got=%b exp=1", walk); end
        rst = 1'b1; tick();
        total += 3;
        if (walk !== 1'b0)      begin bad++; $display("FAIL mid_reset_walk got=%b exp=0", walk); end
        if (dont_walk !== 1'b0) begin bad++; $display("FAIL mid_reset_dont_walk got=%b exp=0", dont_walk); end
        if (ped_pending !== 1'b0) begin bad++; $display("FAIL mid_reset_pending got=%b exp=0", ped_pending); end
        rst = 1'b0; tick(2);
        total++;
        if (walk !== 1'b0) begin bad++; $display("FAIL post_reset_walk got=%b exp=0", walk); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; light_state = L_OFF; ped_btn = 1'b0;
        test_reset();
        test_debounce();
        test_full_walk();
        test_press_mid_red();
        test_abort();
        test_invalid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
